// File: rtl/echo_mix_pkg.sv
// Shared constants for the echo mix stage and the delay lines that feed it.
// TAP_DELAY is the single source of tap lengths; state codes are shared with debug logic.
package echo_mix_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int GAIN_W_DEF    = 4;
  localparam int RAMP_STEP_DEF = 16;
  localparam int CNT_W_DEF     = 7;

  // Delay-line lengths in clk cycles, indexed by tap_sel.
  localparam logic [3:0][6:0] TAP_DELAY = {7'd90, 7'd60, 7'd45, 7'd30};

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  function automatic logic [6:0] tap_delay(input logic [1:0] sel);
    return TAP_DELAY[sel];
  endfunction

endpackage

// File: rtl/echo_mix_stage_gain_ramp_fsm.sv
// Wet-gain sequencer: mutes the wet path while a newly selected tap refills, then ramps
// g_eff up one step every RAMP_STEP clks towards gain; never lets g_eff exceed gain.
module gain_ramp_fsm
  import echo_mix_pkg::*;
#(
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        tap_sel,
  input  logic [GAIN_W-1:0] gain,
  output logic [GAIN_W-1:0] g_eff,
  output logic              wet_muted
);

  localparam int STEP_W = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP - 1);

  logic [1:0]        state;
  logic [1:0]        tap_q;
  logic [CNT_W-1:0]  fill_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [CNT_W-1:0]  reload_cnt;
  logic [GAIN_W-1:0] g_inc;

  assign reload_cnt = CNT_W'(tap_delay(tap_sel));
  assign g_inc      = g_eff + GAIN_W'(1);
  assign wet_muted  = (state == ST_FILL);

  // Disable and tap change both restart the whole fill+ramp sequence and win over
  // any transition the current state would otherwise take.
  always_ff @(posedge clk) begin
    if (rst || !en || (tap_sel != tap_q)) begin
      state    <= ST_FILL;
      tap_q    <= tap_sel;
      fill_cnt <= reload_cnt;
      step_cnt <= '0;
      g_eff    <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          g_eff <= '0;
          if (fill_cnt <= CNT_W'(1)) begin
            state    <= ST_RAMP;
            fill_cnt <= '0;
            step_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt - CNT_W'(1);
          end
        end
        ST_RAMP: begin
          if (gain <= g_eff) begin
            g_eff    <= gain;
            state    <= ST_RUN;
            step_cnt <= '0;
          end else if (step_cnt == STEP_LAST) begin
            g_eff    <= g_inc;
            step_cnt <= '0;
            if (g_inc == gain) begin
              state <= ST_RUN;
            end
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        ST_RUN: begin
          if (gain < g_eff) begin
            g_eff <= gain;
          end else if (gain > g_eff) begin
            state    <= ST_RAMP;
            step_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_FILL;
          fill_cnt <= reload_cnt;
          step_cnt <= '0;
          g_eff    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/echo_mix_stage.sv
// Dry/wet echo mixer: out = dry + (wet*g_eff)>>GAIN_W, 2-clk pipeline, no backpressure.
// ECHO_MIX_SATURATE_EN: clamp overflow to full scale and raise sticky sat_flag; else wrap.
module echo_mix_stage
  import echo_mix_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] dry_in,
  input  logic [DATA_W-1:0] wet_in,
  input  logic              in_valid,
  input  logic [1:0]        tap_sel,
  input  logic [GAIN_W-1:0] gain,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              wet_muted,
  output logic              sat_flag
);

  localparam int PROD_W = DATA_W + GAIN_W;

  logic [GAIN_W-1:0] g_eff;

  gain_ramp_fsm #(
    .GAIN_W    (GAIN_W),
    .RAMP_STEP (RAMP_STEP),
    .CNT_W     (CNT_W)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tap_sel   (tap_sel),
    .gain      (gain),
    .g_eff     (g_eff),
    .wet_muted (wet_muted)
  );

  logic              s1_valid;
  logic [DATA_W-1:0] s1_dry;
  logic [PROD_W-1:0] s1_prod;
  logic [DATA_W-1:0] wet_scaled;
  logic [DATA_W-1:0] mix;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      s1_valid <= 1'b0;
      s1_dry   <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_dry   <= dry_in;
      s1_prod  <= PROD_W'(wet_in) * PROD_W'(g_eff);
    end
  end

  assign wet_scaled = s1_prod[PROD_W-1:GAIN_W];

`ifdef ECHO_MIX_SATURATE_EN
  logic [DATA_W:0] sum;
  logic            sat_q;

  assign sum      = {1'b0, s1_dry} + {1'b0, wet_scaled};
  assign mix      = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  assign sat_flag = sat_q;

  // Sticky across en=0; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (en && s1_valid && sum[DATA_W]) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign mix      = s1_dry + wet_scaled;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= mix;
      end
    end
  end

endmodule

// File: tb/tb_echo_mix_stage.sv
// Scoreboard bench for echo_mix_stage: directed vectors, expected outputs queued at issue.
module tb_echo_mix_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] dry_in = 8'd0;
  logic [7:0] wet_in = 8'd0;
  logic       in_valid = 1'b0;
  logic [1:0] tap_sel = 2'd0;
  logic [3:0] gain = 4'd8;
  logic [7:0] out_data;
  logic       out_valid;
  logic       wet_muted;
  logic       sat_flag;

  echo_mix_stage dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dry_in    (dry_in),
    .wet_in    (wet_in),
    .in_valid  (in_valid),
    .tap_sel   (tap_sel),
    .gain      (gain),
    .out_data  (out_data),
    .out_valid (out_valid),
    .wet_muted (wet_muted),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ECHO_MIX_SATURATE_EN
  localparam int SAT_OUT  = 255;
  localparam int SAT_FLAG = 1;
`else
  localparam int SAT_OUT  = 233;
  localparam int SAT_FLAG = 0;
`endif

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;
  int   n;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [7:0] w);
    dry_in   = d;
    wet_in   = w;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [7:0] d, input logic [7:0] w, input logic [7:0] e);
    exp_t x;
    drive(d, w);
    x.d = e;
    x.c = cyc + 2;
    sb.push_back(x);
  endtask

  // Counts clks with wet_muted high; wet path is silent so outputs equal dry.
  task automatic count_muted(output int cnt);
    cnt = 0;
    while (wet_muted && cnt < 400) begin
      cnt++;
      if (cnt % 8 == 1) issue(8'(cnt * 3), 8'd255, 8'(cnt * 3));
      else in_valid = 1'b0;
      step(1);
    end
    in_valid = 1'b0;
    if (cnt >= 400) chk("mute_timeout", cnt, 0);
  endtask

  initial begin
    fork
      begin : stim
        step(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wet_muted", wet_muted, 1);
        chk("rst_sat_flag", sat_flag, 0);
        rst = 1'b0;

        count_muted(n);
        chk("fill_tap30", n, 30);
        step(48);
        issue(8'd0, 8'd160, 8'd30);
        step(1);
        in_valid = 1'b0;
        step(78);
        issue(8'd100, 8'd200, 8'd187);
        step(1);
        issue(8'd100, 8'd200, 8'd200);
        step(1);
        in_valid = 1'b0;
        chk("run_unmuted", wet_muted, 0);

        gain = 4'd15;
        step(131);
        issue(8'd16, 8'd255, 8'd255);
        step(1);
        in_valid = 1'b0;
        step(3);
        chk("no_sat_at_255", sat_flag, 0);
        issue(8'd250, 8'd255, 8'(SAT_OUT));
        step(1);
        in_valid = 1'b0;
        step(3);
        chk("sat_flag_set", sat_flag, SAT_FLAG);
        issue(8'd10, 8'd0, 8'd10);
        step(1);
        in_valid = 1'b0;
        step(3);
        chk("sat_flag_sticky", sat_flag, SAT_FLAG);

        gain = 4'd8;
        step(2);
        chk("pre_tap_unmuted", wet_muted, 0);
        tap_sel = 2'd3;
        step(1);
        chk("mute_on_tap", wet_muted, 1);
        count_muted(n);
        chk("fill_tap90", n, 90);
        step(49);
        issue(8'd0, 8'd160, 8'd30);
        gain = 4'd2;
        step(1);
        issue(8'd0, 8'd160, 8'd20);
        step(1);
        in_valid = 1'b0;
        step(20);
        issue(8'd0, 8'd160, 8'd20);
        step(1);
        in_valid = 1'b0;

        tap_sel = 2'd0;
        step(30);
        chk("fill_before_zero", wet_muted, 1);
        tap_sel = 2'd2;
        step(1);
        chk("tap_wins", wet_muted, 1);
        count_muted(n);
        chk("fill_tap60_reload", n, 60);
        step(40);

        issue(8'd90, 8'd0, 8'd90);
        step(1);
        drive(8'd77, 8'd0);
        step(1);
        en = 1'b0;
        step(1);
        chk("en0_out_valid", out_valid, 0);
        chk("en0_out_data", out_data, 0);
        chk("en0_muted", wet_muted, 1);
        step(3);
        chk("en0_hold_quiet", out_valid, 0);
        en = 1'b1;
        count_muted(n);
        chk("fill_after_en", n, 60);

        step(5);
        drive(8'd33, 8'd0);
        step(1);
        in_valid = 1'b0;
        rst = 1'b1;
        step(1);
        chk("rst_flush_1", out_valid, 0);
        step(1);
        chk("rst_flush_2", out_valid, 0);
        chk("rst2_out_data", out_data, 0);
        chk("rst2_wet_muted", wet_muted, 1);
        chk("rst2_sat_flag", sat_flag, 0);
        rst = 1'b0;
        step(4);
        chk("sb_drain", sb.size(), 0);
        done = 1'b1;
      end
      begin : mon
        exp_t x;
        while (!done) begin
          @(negedge clk);
          if (out_valid) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: got data %0d with no expected entry (cycle %0d)", out_data, cyc);
            end else begin
              x = sb.pop_front();
              chk("out_data", out_data, x.d);
              chk("out_latency", cyc, x.c);
            end
          end
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
